// File: rtl/fwd_operand_stage_pkg.sv
// Shared types and constants for the forwarding-operand stage.
package fwd_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} fwd_state_t;
    localparam int ERR_CNT_W = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
endpackage

// File: rtl/fwd_operand_stage_if.sv
// Source-bundle / operand handshake bus between forwarding unit, stage and ALU operand register.
interface fwd_operand_stage_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3
);
    localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;

    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [SEL_W-1:0]        sel_i;
    logic [NUM_IN*WIDTH-1:0] data_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [WIDTH-1:0]        data_o;

    modport master (
        output in_valid_i, sel_i, data_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o
    );
    modport slave (
        input  in_valid_i, sel_i, data_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o
    );
endinterface

// File: rtl/fwd_operand_stage_sel_mux.sv
// Combinational source select; out-of-range codes fall back to source 0 and raise oor_o.
module fwd_sel_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]        word_o,
    output logic                    oor_o
);
    always_comb begin
        word_o = data_i[0 +: WIDTH];
        for (int k = 1; k < NUM_IN; k++) begin
            if (sel_i == SEL_W'(k)) word_o = data_i[k*WIDTH +: WIDTH];
        end
    end

    assign oor_o = (32'(sel_i) >= 32'(NUM_IN));
endmodule

// File: rtl/fwd_operand_stage.sv
// Forwarded-operand select with two-entry skid buffer, flush and illegal-select tracking.
// Build option: FWD_OPERAND_ERR_CNT_EN adds the saturating err_cnt_o counter.
module fwd_operand_stage
    import fwd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 err_clr_i,
    output logic                 sel_err_o,
`ifdef FWD_OPERAND_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] err_cnt_o,
`endif
    fwd_operand_stage_if.slave   bus
);
    logic [WIDTH-1:0] sel_word, main_q, skid_q;
    logic             sel_oor, out_valid_q, in_ready_q, acc_in, acc_out, err_evt_q;
    fwd_state_t       state;

    fwd_sel_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_mux (
        .sel_i  (bus.sel_i),
        .data_i (bus.data_i),
        .word_o (sel_word),
        .oor_o  (sel_oor)
    );

    // A flushed input is never accepted, so it cannot raise an error either.
    assign acc_in  = bus.in_valid_i && in_ready_q && !flush_i;
    assign acc_out = out_valid_q && bus.out_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_q      <= '0;
            skid_q      <= '0;
        end else if (flush_i) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (acc_in) begin
                    main_q      <= sel_word;
                    state       <= ONE;
                    out_valid_q <= 1'b1;
                end
                ONE: begin
                    if (acc_in && acc_out) begin
                        main_q <= sel_word;
                    end else if (acc_in) begin
                        skid_q     <= sel_word;
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (acc_out) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: if (acc_out) begin
                    main_q     <= skid_q;
                    state      <= ONE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.in_ready_o  = in_ready_q;
    assign bus.data_o      = main_q;

    // Error event is staged one edge behind acceptance; set beats clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_evt_q <= 1'b0;
            sel_err_o <= 1'b0;
        end else begin
            err_evt_q <= acc_in && sel_oor;
            if (err_evt_q)      sel_err_o <= 1'b1;
            else if (err_clr_i) sel_err_o <= 1'b0;
        end
    end

`ifdef FWD_OPERAND_ERR_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                                err_cnt_o <= '0;
        else if (err_clr_i)                        err_cnt_o <= ERR_CNT_W'(err_evt_q);
        else if (err_evt_q && err_cnt_o != ERR_CNT_MAX) err_cnt_o <= err_cnt_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed self-checking bench for fwd_operand_stage (WIDTH=32, NUM_IN=3).
module tb_fwd_operand_stage;
    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        err_clr_i = 1'b0;
    logic        sel_err_o;
    logic [15:0] err_cnt_o;
    int          n_cmp = 0;
    int          n_fail = 0;

    fwd_operand_stage_if #(.WIDTH(32), .NUM_IN(3)) bus ();

    always #5 clk = ~clk;

`ifdef FWD_OPERAND_ERR_CNT_EN
    fwd_operand_stage #(.WIDTH(32), .NUM_IN(3)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .err_clr_i(err_clr_i),
        .sel_err_o(sel_err_o), .err_cnt_o(err_cnt_o), .bus(bus)
    );
`else
    assign err_cnt_o = 16'h0;
    fwd_operand_stage #(.WIDTH(32), .NUM_IN(3)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .err_clr_i(err_clr_i),
        .sel_err_o(sel_err_o), .bus(bus)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d2,
                         input logic [31:0] d1, input logic [31:0] d0);
        bus.in_valid_i = v;
        bus.sel_i      = s;
        bus.data_i     = {d2, d1, d0};
    endtask

    task automatic test_reset();
        drive(1'b0, 2'd0, 0, 0, 0);
        bus.out_ready_i = 1'b0;
        rst_i = 1'b0;
        #12;
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid_o); end
        n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready_o); end
        n_cmp++; if (bus.data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.data_o); end
        n_cmp++; if (sel_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got %b want 0", sel_err_o); end
`ifdef FWD_OPERAND_ERR_CNT_EN
        n_cmp++; if (err_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_err_cnt got %h want 0", err_cnt_o); end
`endif
        @(negedge clk);
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_basic_burst();
        bus.out_ready_i = 1'b1;
        drive(1'b1, 2'd1, 32'h3, 32'h2, 32'h1);
        tick();
        n_cmp++; if (bus.data_o !== 32'h2) begin n_fail++; $display("FAIL basic_data got %h want 2", bus.data_o); end
        n_cmp++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.out_valid_o); end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'(i % 3), 32'h100*i + 2, 32'h100*i + 1, 32'h100*i);
            tick();
            n_cmp++;
            if (bus.data_o !== 32'h100*i + (i % 3) || bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_%0d got data %h v %b r %b want data %h v 1 r 1",
                         i, bus.data_o, bus.out_valid_o, bus.in_ready_o, 32'h100*i + (i % 3));
            end
        end
        drive(1'b0, 2'd0, 0, 0, 0);
        tick();
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL burst_drain got %b want 0", bus.out_valid_o); end
    endtask

    task automatic test_back_to_back_fill();
        bus.out_ready_i = 1'b0;
        drive(1'b1, 2'd0, 0, 0, 32'hAAAA_0001);
        tick();
        drive(1'b1, 2'd2, 32'hBBBB_0002, 0, 0);
        tick();
        n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", bus.in_ready_o); end
        drive(1'b1, 2'd0, 0, 0, 32'hDEAD_BEEF);
        tick();
        n_cmp++; if (bus.data_o !== 32'hAAAA_0001 || bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL fill_hold got %h v %b want aaaa0001 v 1", bus.data_o, bus.out_valid_o); end
        drive(1'b0, 2'd0, 0, 0, 0);
        bus.out_ready_i = 1'b1;
        tick();
        n_cmp++; if (bus.data_o !== 32'hBBBB_0002 || bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_second got %h r %b want bbbb0002 r 1", bus.data_o, bus.in_ready_o); end
        tick();
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL fill_empty got %b want 0", bus.out_valid_o); end
    endtask

    task automatic test_sel_err();
        bus.out_ready_i = 1'b1;
        drive(1'b1, 2'd3, 32'h33, 32'h22, 32'h11);
        tick();
        n_cmp++; if (bus.data_o !== 32'h11) begin n_fail++; $display("FAIL err_data got %h want 11", bus.data_o); end
        n_cmp++; if (sel_err_o !== 1'b0) begin n_fail++; $display("FAIL err_early got %b want 0", sel_err_o); end
        drive(1'b0, 2'd0, 0, 0, 0);
        tick();
        n_cmp++; if (sel_err_o !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", sel_err_o); end
`ifdef FWD_OPERAND_ERR_CNT_EN
        n_cmp++; if (err_cnt_o !== 16'd1) begin n_fail++; $display("FAIL err_cnt_one got %h want 1", err_cnt_o); end
`endif
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        n_cmp++; if (sel_err_o !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b want 0", sel_err_o); end
`ifdef FWD_OPERAND_ERR_CNT_EN
        n_cmp++; if (err_cnt_o !== 16'd0) begin n_fail++; $display("FAIL err_cnt_clr got %h want 0", err_cnt_o); end
`endif
    endtask

    task automatic test_flush();
        bus.out_ready_i = 1'b0;
        drive(1'b1, 2'd0, 0, 0, 32'hA1);
        tick();
        drive(1'b1, 2'd0, 0, 0, 32'hB2);
        tick();
        drive(1'b1, 2'd0, 0, 0, 32'hC3);
        flush_i = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_two got v %b r %b want v 0 r 1", bus.out_valid_o, bus.in_ready_o); end
        n_cmp++; if (bus.data_o !== 32'hA1) begin n_fail++; $display("FAIL flush_data_kept got %h want a1", bus.data_o); end
        // Flush while ready: the concurrent illegal select must be dropped entirely.
        drive(1'b1, 2'd3, 0, 0, 32'hD4);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 2'd0, 0, 0, 0);
        bus.out_ready_i = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got v %b want 0", bus.out_valid_o); end
        n_cmp++; if (sel_err_o !== 1'b0) begin n_fail++; $display("FAIL flush_no_err got %b want 0", sel_err_o); end
    endtask

    task automatic test_async_reset();
        bus.out_ready_i = 1'b1;
        drive(1'b1, 2'd3, 0, 0, 32'h55);
        tick();
        drive(1'b1, 2'd1, 0, 32'h66, 0);
        tick();
        #2;
        rst_i = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.data_o !== 32'h0 || sel_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got v %b r %b d %h e %b want 0 1 0 0", bus.out_valid_o, bus.in_ready_o, bus.data_o, sel_err_o);
        end
        #2;
        rst_i = 1'b1;
        drive(1'b1, 2'd2, 32'h77, 0, 0);
        tick();
        n_cmp++; if (bus.data_o !== 32'h77 || bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL async_resume got %h v %b want 77 v 1", bus.data_o, bus.out_valid_o); end
        drive(1'b0, 2'd0, 0, 0, 0);
        tick();
        n_cmp++; if (sel_err_o !== 1'b0) begin n_fail++; $display("FAIL async_no_err got %b want 0", sel_err_o); end
    endtask

`ifdef FWD_OPERAND_ERR_CNT_EN
    task automatic test_cnt_sat();
        bus.out_ready_i = 1'b1;
        drive(1'b1, 2'd3, 0, 0, 0);
        for (int i = 0; i < 65535; i++) tick();
        drive(1'b0, 2'd0, 0, 0, 0);
        tick();
        n_cmp++; if (err_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_max got %h want ffff", err_cnt_o); end
        drive(1'b1, 2'd3, 0, 0, 0);
        tick();
        drive(1'b0, 2'd0, 0, 0, 0);
        tick();
        n_cmp++; if (err_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat got %h want ffff", err_cnt_o); end
        err_clr_i = 1'b1;
        drive(1'b1, 2'd3, 0, 0, 0);
        tick();
        err_clr_i = 1'b0;
        drive(1'b0, 2'd0, 0, 0, 0);
        tick();
        n_cmp++; if (err_cnt_o !== 16'd1 || sel_err_o !== 1'b1) begin n_fail++; $display("FAIL cnt_clr_inc got %h e %b want 1 e 1", err_cnt_o, sel_err_o); end
    endtask
`endif

    initial begin
        bus.out_ready_i = 1'b0;
        drive(1'b0, 2'd0, 0, 0, 0);
        test_reset();
        test_basic_burst();
        test_back_to_back_fill();
        test_sel_err();
        test_flush();
        test_async_reset();
`ifdef FWD_OPERAND_ERR_CNT_EN
        test_cnt_sat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
